// File: rtl/instmem_arb_pkg.sv
// Shared types and sizing for the instruction-memory arbiter and boot sequencer.
package instmem_arb_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int STARVE_W   = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags count == limit.
module starve_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == limit);

endmodule

// File: rtl/instmem_arbiter.sv
// Single-port instruction memory arbiter: loader-only BOOT phase, then fetch-priority
// RUN phase with a starvation guard that bounds loader latency.
module instmem_arbiter
    import instmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    input  logic              l_done,
    output logic              boot,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              f_rvalid_q;
    logic              l_rvalid_q;
    logic              at_limit;
    logic              in_run;

    // Handshake: a requester holds req/addr/data until the cycle its gnt is 1; that
    // cycle consumes the request. Reads return rvalid/rdata exactly one cycle later.
    always_comb begin
        in_run    = (state == RUN);
        l_gnt     = reset & l_req & (!in_run | !f_req | at_limit);
        f_gnt     = reset & in_run & f_req & !l_gnt;
        mem_write = l_gnt & l_we;
        if (l_gnt) begin
            mem_addr = l_addr;
        end else if (f_gnt) begin
            mem_addr = f_addr;
        end else begin
            mem_addr = addr_q;
        end
    end

    assign mem_datain = l_wdata;

    starve_counter #(
        .W(STARVE_W)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clr      (!in_run | l_gnt),
        .inc      (in_run & l_req & !l_gnt),
        .limit    (STARVE_W'(STARVE_LIMIT)),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= BOOT;
            addr_q     <= '0;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            if (state == BOOT && l_done) begin
                state <= RUN;
            end
            if (l_gnt || f_gnt) begin
                addr_q <= mem_addr;
            end
            f_rvalid_q <= f_gnt;
            l_rvalid_q <= l_gnt & !l_we;
        end
    end

    // Gating with reset drops any response still in flight when reset arrives.
    assign f_rvalid = f_rvalid_q & reset;
    assign l_rvalid = l_rvalid_q & reset;
    assign f_rdata  = mem_dataout;
    assign l_rdata  = mem_dataout;
    assign boot     = (state == BOOT);

endmodule

// File: tb/tb_instmem_arbiter.sv
// Self-checking bench for instmem_arbiter with a behavioural registered-read memory.
module tb_instmem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [15:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_done;
  logic        boot;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  instmem_arbiter #(
    .ADDR_W(16),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_gnt       (f_gnt),
    .f_rvalid    (f_rvalid),
    .f_rdata     (f_rdata),
    .l_req       (l_req),
    .l_we        (l_we),
    .l_addr      (l_addr),
    .l_wdata     (l_wdata),
    .l_gnt       (l_gnt),
    .l_rvalid    (l_rvalid),
    .l_rdata     (l_rdata),
    .l_done      (l_done),
    .boot        (boot),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory attached to the arbiter: registered read, write on mem_write
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_datain;
    mem_dataout <= mem[mem_addr[7:0]];
  end

  // scoreboard state
  logic [31:0] ref_mem [0:255];
  logic [31:0] f_exp_q [$];
  logic [31:0] l_exp_q [$];
  logic        f_pend;
  logic        l_pend;
  logic        exp_boot;
  logic [15:0] last_addr;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs, check at negedge, advance past posedge.
  task automatic step(input logic rst, input logic fr, input logic [15:0] fa,
                      input logic lr, input logic lwe, input logic [15:0] la,
                      input logic [31:0] lwd, input logic ld,
                      input logic ef, input logic el);
    logic [31:0] d;
    reset = rst; f_req = fr; f_addr = fa;
    l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd; l_done = ld;
    @(negedge clk);
    check("boot", boot, exp_boot);
    check("f_rvalid", f_rvalid, f_pend & rst);
    check("l_rvalid", l_rvalid, l_pend & rst);
    if (f_pend) begin
      d = f_exp_q.pop_front();
      if (rst && f_rvalid) check("f_rdata", f_rdata, d);
    end
    if (l_pend) begin
      d = l_exp_q.pop_front();
      if (rst && l_rvalid) check("l_rdata", l_rdata, d);
    end
    check("f_gnt", f_gnt, ef);
    check("l_gnt", l_gnt, el);
    check("mem_write", mem_write, el & lwe);
    check("mem_addr", mem_addr, el ? la : (ef ? fa : last_addr));
    if (el && lwe) check("mem_datain", mem_datain, lwd);
    f_pend = ef;
    l_pend = el & !lwe;
    if (ef) f_exp_q.push_back(ref_mem[fa[7:0]]);
    if (el && !lwe) l_exp_q.push_back(ref_mem[la[7:0]]);
    if (el && lwe) ref_mem[la[7:0]] = lwd;
    if (!rst) last_addr = 16'h0;
    else if (el) last_addr = la;
    else if (ef) last_addr = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ef_dummy);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, ef_dummy, 1'b0);
  endtask

  logic [31:0] words [0:2];

  initial begin
    n_checks = 0; n_pass = 0;
    f_pend = 1'b0; l_pend = 1'b0; exp_boot = 1'b1; last_addr = 16'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    reset = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_done = 1'b0;
    @(posedge clk); #1;

    // reset held low, requests present but must not be granted
    step(1'b0, 1'b1, 16'h4, 1'b1, 1'b1, 16'h4, 32'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h4, 1'b1, 1'b1, 16'h4, 32'h5, 1'b0, 1'b0, 1'b0);

    // BOOT load with fetch requesting throughout
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'h10, 1'b1, 1'b1, 16'(i), words[i], 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h10, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    exp_boot = 1'b0;

    // streaming fetch of the boot image
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // starvation guard: four denials, grant on the fifth, then counting restarts
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        step(1'b1, 1'b1, 16'($urandom_range(0, 2)), 1'b1, 1'b0, 16'h5, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'h1, 1'b1, 1'b0, 16'h5, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    idle(1'b0);

    // idle fetch side: loader write granted at once, read back by fetch
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h7, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    // loader read with fetch idle
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h2, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // reset arriving while a fetch response is in flight
    step(1'b1, 1'b1, 16'h1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_boot = 1'b1;
    step(1'b1, 1'b1, 16'h3, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // l_done together with a final write: write lands, RUN next cycle
    step(1'b1, 1'b1, 16'h3, 1'b1, 1'b1, 16'h9, 32'hCAFE0009, 1'b1, 1'b0, 1'b1);
    exp_boot = 1'b0;
    step(1'b1, 1'b1, 16'h9, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // idle address hold after a fetch of 0x00AB
    step(1'b1, 1'b1, 16'h00AB, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);

    check("f_queue_empty", f_exp_q.size(), 0);
    check("l_queue_empty", l_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
